// File: rtl/fb_pkg.sv
// Shared constants, colours and controller state type for the framebuffer write side.
package fb_pkg;

  localparam int unsigned RESOLUTION_H = 640;
  localparam int unsigned RESOLUTION_V = 480;
  localparam int unsigned HPOS_WIDTH   = 10;
  localparam int unsigned VPOS_WIDTH   = 9;
  localparam int unsigned ADDR_WIDTH   = 19;
  localparam int unsigned BRUSH_SIZE   = 20;

  localparam logic [2:0] BRUSH_COLOR = 3'b101;
  localparam logic [2:0] CLEAR_COLOR = 3'b000;

  typedef enum logic [1:0] {
    StIdle,
    StPaint,
    StClear,
    StDone
  } fb_state_e;

endpackage

// File: rtl/rect_scanner.sv
// Row-major walker over an inclusive rectangle, producing linear pixel addresses
// from a running row base (no multiplier in the per-pixel path).
module rect_scanner #(
  parameter int unsigned RowStride = 640,
  parameter int unsigned XW        = 10,
  parameter int unsigned YW        = 9,
  parameter int unsigned AW        = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  input  logic          advance,
  output logic [AW-1:0] fb_addr,
  output logic          last,
  output logic          valid
);

  logic [XW-1:0] x_q, x_d, x0_q, x0_d, x1_q, x1_d;
  logic [YW-1:0] y_q, y_d, y1_q, y1_d;
  logic [AW-1:0] row_q, row_d, addr_q, addr_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] start_row;
  logic [AW-1:0] next_row;

  // y0 * RowStride as a constant shift-add, only evaluated on load.
  always_comb begin
    start_row = '0;
    for (int i = 0; i < 32; i++) begin
      if (RowStride[i]) begin
        start_row = start_row + (AW'(y0) << i);
      end
    end
  end

  assign next_row = row_q + AW'(RowStride);
  assign last     = valid_q && (x_q == x1_q) && (y_q == y1_q);
  assign fb_addr  = addr_q;
  assign valid    = valid_q;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    row_d   = row_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    if (start) begin
      x0_d    = x0;
      x1_d    = x1;
      y1_d    = y1;
      x_d     = x0;
      y_d     = y0;
      row_d   = start_row;
      addr_d  = start_row + AW'(x0);
      valid_d = 1'b1;
    end else if (advance && valid_q) begin
      if (last) begin
        valid_d = 1'b0;
      end else if (x_q == x1_q) begin
        x_d    = x0_q;
        y_d    = y_q + 1'b1;
        row_d  = next_row;
        addr_d = next_row + AW'(x0_q);
      end else begin
        x_d    = x_q + 1'b1;
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/fb_paint_ctrl.sv
// Framebuffer write-side controller: turns brush paint and clear-screen requests
// into a stream of single-pixel writes with a ready handshake.
module fb_paint_ctrl #(
  parameter int unsigned RESOLUTION_H = fb_pkg::RESOLUTION_H,
  parameter int unsigned RESOLUTION_V = fb_pkg::RESOLUTION_V,
  parameter int unsigned HPOS_WIDTH   = fb_pkg::HPOS_WIDTH,
  parameter int unsigned VPOS_WIDTH   = fb_pkg::VPOS_WIDTH,
  parameter int unsigned ADDR_WIDTH   = fb_pkg::ADDR_WIDTH,
  parameter int unsigned BRUSH_SIZE   = fb_pkg::BRUSH_SIZE,
  parameter logic [2:0]  BRUSH_COLOR  = fb_pkg::BRUSH_COLOR,
  parameter logic [2:0]  CLEAR_COLOR  = fb_pkg::CLEAR_COLOR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  paint_req,
  input  logic                  clear_req,
  input  logic [HPOS_WIDTH-1:0] cursor_xpos,
  input  logic [VPOS_WIDTH-1:0] cursor_ypos,
  input  logic                  fb_ready,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic [2:0]            fb_wdata,
  output logic                  busy,
  output logic                  done
);

  import fb_pkg::*;

  fb_state_e state_q, state_d;
  logic      pend_q, pend_d;
  logic      busy_q, busy_d;
  logic      done_q, done_d;
  logic [2:0] wdata_q, wdata_d;

  logic [31:0] cx, cy, px0, px1, py0, py1;
  logic        rect_empty;
  logic        scan_start, scan_clear, scan_last, scan_valid, accept;
  logic [HPOS_WIDTH-1:0] scan_x0, scan_x1;
  logic [VPOS_WIDTH-1:0] scan_y0, scan_y1;

  // Clip in 32-bit so neither the low-side subtract nor the high-side add can wrap.
  always_comb begin
    cx  = 32'(cursor_xpos);
    cy  = 32'(cursor_ypos);
    px0 = (cx < BRUSH_SIZE) ? 32'd0 : cx - BRUSH_SIZE;
    px1 = (cx + BRUSH_SIZE > RESOLUTION_H - 1) ? RESOLUTION_H - 1 : cx + BRUSH_SIZE;
    py0 = (cy < BRUSH_SIZE) ? 32'd0 : cy - BRUSH_SIZE;
    py1 = (cy + BRUSH_SIZE > RESOLUTION_V - 1) ? RESOLUTION_V - 1 : cy + BRUSH_SIZE;
    rect_empty = (px0 > px1) || (py0 > py1);
  end

  always_comb begin
    if (scan_clear) begin
      scan_x0 = '0;
      scan_x1 = HPOS_WIDTH'(RESOLUTION_H - 1);
      scan_y0 = '0;
      scan_y1 = VPOS_WIDTH'(RESOLUTION_V - 1);
    end else begin
      scan_x0 = HPOS_WIDTH'(px0);
      scan_x1 = HPOS_WIDTH'(px1);
      scan_y0 = VPOS_WIDTH'(py0);
      scan_y1 = VPOS_WIDTH'(py1);
    end
  end

  assign accept = scan_valid & fb_ready;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wdata_d    = wdata_q;
    scan_start = 1'b0;
    scan_clear = 1'b0;
    if (clear_req && (state_q != StIdle)) begin
      pend_d = 1'b1;
    end
    case (state_q)
      StIdle: begin
        if (pend_q || clear_req) begin
          state_d    = StClear;
          pend_d     = 1'b0;
          scan_start = 1'b1;
          scan_clear = 1'b1;
          wdata_d    = CLEAR_COLOR;
          busy_d     = 1'b1;
        end else if (paint_req) begin
          busy_d  = 1'b1;
          wdata_d = BRUSH_COLOR;
          if (rect_empty) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d    = StPaint;
            scan_start = 1'b1;
          end
        end
      end
      StPaint, StClear: begin
        if (accept && scan_last) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wdata_q <= wdata_d;
    end
  end

  rect_scanner #(
    .RowStride (RESOLUTION_H),
    .XW        (HPOS_WIDTH),
    .YW        (VPOS_WIDTH),
    .AW        (ADDR_WIDTH)
  ) u_scanner (
    .clk     (clk),
    .rst_n   (reset),
    .start   (scan_start),
    .x0      (scan_x0),
    .x1      (scan_x1),
    .y0      (scan_y0),
    .y1      (scan_y1),
    .advance (accept),
    .fb_addr (fb_addr),
    .last    (scan_last),
    .valid   (scan_valid)
  );

  assign fb_we    = scan_valid;
  assign fb_wdata = wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fb_paint_ctrl.sv
// Directed bench: a full-size instance for brush scans and a reduced-resolution
// instance so complete clears and queued clears fit in a short run.
module tb_fb_paint_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Full-size instance (640x480, brush 20)
  logic        m_rst_n, m_paint, m_clear, m_ready;
  logic [9:0]  m_cx;
  logic [8:0]  m_cy;
  logic        m_we, m_busy, m_done;
  logic [18:0] m_addr;
  logic [2:0]  m_wdata;

  // Small instance (40x30, brush 3)
  logic        s_rst_n, s_paint, s_clear, s_ready;
  logic [5:0]  s_cx;
  logic [4:0]  s_cy;
  logic        s_we, s_busy, s_done;
  logic [10:0] s_addr;
  logic [2:0]  s_wdata;

  int tests = 0;
  int fails = 0;

  fb_paint_ctrl u_main (
    .clk         (clk),
    .reset       (m_rst_n),
    .paint_req   (m_paint),
    .clear_req   (m_clear),
    .cursor_xpos (m_cx),
    .cursor_ypos (m_cy),
    .fb_ready    (m_ready),
    .fb_we       (m_we),
    .fb_addr     (m_addr),
    .fb_wdata    (m_wdata),
    .busy        (m_busy),
    .done        (m_done)
  );

  fb_paint_ctrl #(
    .RESOLUTION_H (40),
    .RESOLUTION_V (30),
    .HPOS_WIDTH   (6),
    .VPOS_WIDTH   (5),
    .ADDR_WIDTH   (11),
    .BRUSH_SIZE   (3)
  ) u_small (
    .clk         (clk),
    .reset       (s_rst_n),
    .paint_req   (s_paint),
    .clear_req   (s_clear),
    .cursor_xpos (s_cx),
    .cursor_ypos (s_cy),
    .fb_ready    (s_ready),
    .fb_we       (s_we),
    .fb_addr     (s_addr),
    .fb_wdata    (s_wdata),
    .busy        (s_busy),
    .done        (s_done)
  );

  task automatic set_paint(input bit sel, input logic v);
    if (sel) s_paint = v; else m_paint = v;
  endtask

  task automatic set_clear(input bit sel, input logic v);
    if (sel) s_clear = v; else m_clear = v;
  endtask

  task automatic set_ready(input bit sel, input logic v);
    if (sel) s_ready = v; else m_ready = v;
  endtask

  // Drives one operation on the selected instance and walks a reference model of
  // the row-major scan alongside it. kind: 0 paint pulse, 1 clear pulse, 2 none.
  task automatic scan(input bit sel, input int kind, input int cx, input int cy,
                      input int x0, input int x1, input int y0, input int y1,
                      input logic [2:0] exp_wd, input int stall_idx,
                      input int clr_a, input int clr_b, input int budget,
                      output int nwr, output int first, output int lasta,
                      output int bad, output bit done_ok);
    int h, total, ex, ey, idx, stall;
    logic we, dn, bsy, rdy;
    logic [31:0] addr, exp_addr;
    logic [2:0] wd;
    h = sel ? 40 : 640;
    total = (x0 > x1 || y0 > y1) ? 0 : (x1 - x0 + 1) * (y1 - y0 + 1);
    ex = x0; ey = y0; idx = 0; stall = 0;
    nwr = 0; first = -1; lasta = -1; bad = 0; done_ok = 1'b0;
    if (sel) begin s_cx = 6'(cx); s_cy = 5'(cy); end
    else begin m_cx = 10'(cx); m_cy = 9'(cy); end
    set_ready(sel, 1'b1);
    if (kind == 0) set_paint(sel, 1'b1);
    if (kind == 1) set_clear(sel, 1'b1);
    @(posedge clk); #1;
    set_paint(sel, 1'b0);
    set_clear(sel, 1'b0);
    for (int c = 0; c < budget; c++) begin
      we   = sel ? s_we : m_we;
      dn   = sel ? s_done : m_done;
      bsy  = sel ? s_busy : m_busy;
      wd   = sel ? s_wdata : m_wdata;
      addr = sel ? 32'(s_addr) : 32'(m_addr);
      set_clear(sel, (c == clr_a || c == clr_b) ? 1'b1 : 1'b0);
      if (idx < total) begin
        exp_addr = 32'(ey * h + ex);
        if (we !== 1'b1 || addr !== exp_addr || wd !== exp_wd || bsy !== 1'b1 || dn !== 1'b0)
          bad++;
        rdy = !(idx == stall_idx && stall < 3);
        if (!rdy) stall++;
        set_ready(sel, rdy);
        if (rdy && we === 1'b1) begin
          if (first < 0) first = int'(addr);
          lasta = int'(addr);
          nwr++;
          idx++;
          if (ex == x1) begin ex = x0; ey++; end
          else ex++;
        end
      end else begin
        done_ok = (dn === 1'b1 && we === 1'b0 && bsy === 1'b1);
        set_clear(sel, 1'b0);
        @(posedge clk); #1;
        dn  = sel ? s_done : m_done;
        bsy = sel ? s_busy : m_busy;
        done_ok = done_ok && (dn === 1'b0) && (bsy === 1'b0);
        break;
      end
      @(posedge clk); #1;
    end
    set_ready(sel, 1'b1);
    set_clear(sel, 1'b0);
  endtask

  task automatic test_reset();
    m_rst_n = 1'b0; s_rst_n = 1'b0;
    m_paint = 0; m_clear = 0; m_ready = 1; m_cx = '0; m_cy = '0;
    s_paint = 0; s_clear = 0; s_ready = 1; s_cx = '0; s_cy = '0;
    #1;
    tests++;
    if ({m_we, m_addr, m_wdata, m_busy, m_done} !== 25'd0) begin
      fails++;
      $display("FAIL reset_main outputs got %h want 0", {m_we, m_addr, m_wdata, m_busy, m_done});
    end
    tests++;
    if ({s_we, s_addr, s_wdata, s_busy, s_done} !== 17'd0) begin
      fails++;
      $display("FAIL reset_small outputs got %h want 0", {s_we, s_addr, s_wdata, s_busy, s_done});
    end
    repeat (2) @(posedge clk);
    #1;
    m_rst_n = 1'b1; s_rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (m_we !== 1'b0 || m_busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset we/busy got %b%b want 00", m_we, m_busy);
    end
  endtask

  task automatic check_scan(input string name, input int nwr, input int exp_n,
                            input int first, input int exp_first, input int lasta,
                            input int exp_last, input int bad, input bit done_ok);
    tests++;
    if (nwr !== exp_n) begin fails++; $display("FAIL %s count got %0d want %0d", name, nwr, exp_n); end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL %s bad_cycles got %0d want 0", name, bad); end
    tests++;
    if (first !== exp_first) begin
      fails++; $display("FAIL %s first_addr got %0d want %0d", name, first, exp_first);
    end
    tests++;
    if (lasta !== exp_last) begin
      fails++; $display("FAIL %s last_addr got %0d want %0d", name, lasta, exp_last);
    end
    tests++;
    if (done_ok !== 1'b1) begin fails++; $display("FAIL %s done_pulse got 0 want 1", name); end
  endtask

  task automatic test_paint_center();
    int n, f, l, b; bit d;
    scan(0, 0, 320, 240, 300, 340, 220, 260, 3'b101, -1, -1, -1, 4000, n, f, l, b, d);
    check_scan("paint_center", n, 1681, f, 141100, l, 166740, b, d);
  endtask

  task automatic test_paint_clip_low();
    int n, f, l, b; bit d;
    scan(0, 0, 5, 5, 0, 25, 0, 25, 3'b101, -1, -1, -1, 2000, n, f, l, b, d);
    check_scan("paint_clip_low", n, 676, f, 0, l, 16025, b, d);
  endtask

  task automatic test_paint_offscreen();
    int n, f, l, b; bit d;
    scan(0, 0, 700, 100, 680, 639, 80, 120, 3'b101, -1, -1, -1, 20, n, f, l, b, d);
    tests++;
    if (n !== 0) begin fails++; $display("FAIL offscreen count got %0d want 0", n); end
    tests++;
    if (d !== 1'b1) begin fails++; $display("FAIL offscreen done_pulse got 0 want 1"); end
  endtask

  task automatic test_stall();
    int n, f, l, b; bit d;
    scan(0, 0, 320, 240, 300, 340, 220, 260, 3'b101, 45, -1, -1, 4000, n, f, l, b, d);
    check_scan("paint_stall", n, 1681, f, 141100, l, 166740, b, d);
  endtask

  task automatic test_clear_full();
    int n, f, l, b; bit d;
    scan(1, 1, 0, 0, 0, 39, 0, 29, 3'b000, -1, -1, -1, 3000, n, f, l, b, d);
    check_scan("clear_full", n, 1200, f, 0, l, 1199, b, d);
  endtask

  task automatic test_paint_clip_high();
    int n, f, l, b; bit d;
    scan(1, 0, 38, 28, 35, 39, 25, 29, 3'b101, -1, -1, -1, 200, n, f, l, b, d);
    check_scan("paint_clip_high", n, 25, f, 1035, l, 1199, b, d);
  endtask

  task automatic test_pending_clear();
    int n, f, l, b, extra; bit d;
    scan(1, 0, 20, 15, 17, 23, 12, 18, 3'b101, -1, 5, 20, 200, n, f, l, b, d);
    check_scan("pend_paint", n, 49, f, 497, l, 743, b, d);
    scan(1, 2, 20, 15, 0, 39, 0, 29, 3'b000, -1, -1, -1, 3000, n, f, l, b, d);
    check_scan("pend_clear", n, 1200, f, 0, l, 1199, b, d);
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      if (s_we !== 1'b0) extra++;
      @(posedge clk); #1;
    end
    tests++;
    if (extra !== 0) begin fails++; $display("FAIL pend_single_clear writes got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid_clear();
    int bad, idle_bad;
    bad = 0; idle_bad = 0;
    m_ready = 1'b1;
    m_clear = 1'b1;
    @(posedge clk); #1;
    m_clear = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (m_we !== 1'b1 || m_addr !== 19'(c) || m_wdata !== 3'b000) bad++;
      @(posedge clk); #1;
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL clear_seq bad_cycles got %0d want 0", bad); end
    m_rst_n = 1'b0;
    #1;
    tests++;
    if ({m_we, m_addr, m_wdata, m_busy, m_done} !== 25'd0) begin
      fails++;
      $display("FAIL reset_abort outputs got %h want 0", {m_we, m_addr, m_wdata, m_busy, m_done});
    end
    @(posedge clk); @(posedge clk); #1;
    m_rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (m_we !== 1'b0 || m_busy !== 1'b0) idle_bad++;
    end
    tests++;
    if (idle_bad !== 0) begin
      fails++; $display("FAIL post_reset_idle bad_cycles got %0d want 0", idle_bad);
    end
  endtask

  initial begin
    test_reset();
    test_paint_center();
    test_paint_clip_low();
    test_paint_offscreen();
    test_stall();
    test_clear_full();
    test_paint_clip_high();
    test_pending_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
